multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execution unit directly downstream of the CPU control unit.
- Accepts an opcode and two 16-bit operands under a bgn/rdy handshake.
- Single-cycle ops (add/sub/logic/shift/rotate) and iterative 16-step MUL/DIV/MOD produce two result words (acc1, acc2) plus four registered flags.
- The control unit holds bgn high until rdy, then drops bgn and advances PC.

Parameters:
- WIDTH, 16, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bgn  in  1  start request; level, held by control unit until rdy seen
- opcode  in  6  [5:1] operation, [0] immediate flag (ignored here; operand mux is upstream)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- acc1  out  WIDTH  primary result
- acc2  out  WIDTH  secondary result (MUL high word, DIV remainder, MOD quotient, else 0)
- zero  out  1  acc1 == 0
- negative  out  1  acc1[WIDTH-1]
- carry  out  1  carry/borrow/shifted-out bit
- overflow  out  1  signed overflow / divide-by-zero
- rdy  out  1  result valid; held until bgn drops

Behaviour:
- Reset (async, any state incl. mid-iteration): state=IDLE; acc1, acc2, all flags, rdy, iteration counter = 0.
- Op codes (opcode[5:1]): ADD 00001, SUB 00010, LSR 00011, LSL 00100, RSR 00101, RSL 00110, MOV 00111, MUL 01000, DIV 01001, MOD 01010, AND 01011, OR 01100, XOR 01101, NOT 01110, CMP 01111, TST 10000, INC 10001, DEC 10010.
- FSM states: IDLE, CALC, DONE.
- IDLE: on a clk edge with bgn=1, latch opcode, A, B.
  - Single-cycle op: result and flags are registered at that same edge; next state DONE. rdy=1 one cycle after the capture edge.
  - MUL/DIV/MOD: next state CALC, counter=0.
- CALC: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle. After WIDTH steps, results and flags are registered; next state DONE. rdy rises exactly WIDTH+1 edges after the capture edge (17 for default).
- DONE: rdy=1; outputs stable. bgn=0 at an edge -> IDLE, rdy=0. bgn still 1 -> remain DONE, no restart. A new op needs bgn low for ≥1 edge.
- Inputs A/B/opcode changing after capture: ignored until next IDLE capture.
- Arithmetic:
  - ADD: acc1=A+B; carry=unsigned carry-out; overflow=signed overflow.
  - SUB and CMP: acc1=A−B; carry=1 when A<B unsigned (borrow); overflow=signed overflow. CMP result is not written back by the control unit.
  - INC/DEC: acc1=A±1; carry/overflow as ADD/SUB with B=1.
  - LSR/LSL: logical shift of A by B[3:0]. Shift by 0: acc1=A, carry=0. Otherwise carry = last bit shifted out.
  - RSR/RSL: rotate A by B[3:0]. Carry = bit that last wrapped (0 when amount=0).
  - MOV: acc1=B.
  - AND/OR/XOR/TST: bitwise A op B (TST=AND). NOT: acc1=~A.
  - MOV/logic/NOT/TST: carry=0, overflow=0.
  - MUL: unsigned A×B; acc1=low word, acc2=high word; carry=(acc2!=0); overflow=0.
  - DIV: unsigned; acc1=quotient, acc2=remainder. MOD: acc1=remainder, acc2=quotient. carry=0.
  - Divide-by-zero (B=0, DIV/MOD): skip CALC, complete single-cycle. Quotient=all ones, remainder=A, overflow=1.
- zero/negative are always derived from the final acc1. acc2=0 for all non-MUL/DIV/MOD ops.
- Unlisted opcodes (HLT 00000, NOP 11111, branches, etc.): single-cycle; acc1=acc2=0; all flags hold previous values; rdy as normal.
- Flags persist in IDLE until the next op completes.

Test Plan:
- ADD A=0x7FFF B=0x0001 -> rdy 1 cycle after capture; acc1=0x8000, negative=1, overflow=1, carry=0, zero=0.
- SUB A=0x0003 B=0x0005 -> acc1=0xFFFE, carry=1, negative=1, overflow=0. Then CMP A=B=0x1234 -> zero=1, carry=0.
- MUL A=0x1234 B=0x0100 -> rdy exactly 17 edges after capture; acc1=0x3400, acc2=0x0012, carry=1.
- DIV A=100 B=7 -> acc1=14, acc2=2. MOD same operands -> acc1=2, acc2=14. DIV A=0x0042 B=0 -> 1-cycle rdy, acc1=0xFFFF, acc2=0x0042, overflow=1.
- RSL A=0x8001 B=1 -> acc1=0x0003, carry=1. LSR A=0x0003 B=1 -> acc1=0x0001, carry=1. LSL by 0 -> acc1=A, carry=0.
- Handshake/reset:
  - Hold bgn high 5 cycles past rdy -> rdy stays 1, outputs unchanged, no second op. Drop bgn -> rdy=0 next edge.
  - Assert rst at step 8 of MUL -> outputs 0 immediately, state IDLE. Subsequent ADD 2+3 -> acc1=5.

Source files
------------

// File: rtl/multicycle_alu_if.sv
// Request/result bundle between the CPU control unit and the multicycle ALU.
// bgn/rdy: the master raises bgn with stable opcode/A/B and holds it until rdy; rdy stays high while bgn does.
interface multicycle_alu_if #(parameter int WIDTH = 16) ();
  logic             bgn;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] acc1;
  logic [WIDTH-1:0] acc2;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             rdy;
  logic [1:0]       state_dbg;

  modport master (
    output bgn, opcode, A, B,
    input  acc1, acc2, zero, negative, carry, overflow, rdy, state_dbg
  );

  modport slave (
    input  bgn, opcode, A, B,
    output acc1, acc2, zero, negative, carry, overflow, rdy, state_dbg
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execution unit: single-cycle ALU ops plus iterative shift-add MUL and restoring DIV/MOD.
// Results and flags are registered; rdy is raised in DONE and dropped once bgn falls.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  multicycle_alu_if.slave bus
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSR = 5'b00011;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_MOV = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;
  localparam logic [4:0] OP_MOD = 5'b01010;
  localparam logic [4:0] OP_AND = 5'b01011;
  localparam logic [4:0] OP_OR  = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_NOT = 5'b01110;
  localparam logic [4:0] OP_CMP = 5'b01111;
  localparam logic [4:0] OP_TST = 5'b10000;
  localparam logic [4:0] OP_INC = 5'b10001;
  localparam logic [4:0] OP_DEC = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] acc1_q;
  logic [WIDTH-1:0] acc2_q;
  logic             zero_q;
  logic             negative_q;
  logic             carry_q;
  logic             overflow_q;
  logic             rdy_q;

  // Single-cycle datapath works straight off the bus so results land on the capture edge.
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SH_W-1:0]  amt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] shr_last;
  logic [WIDTH-1:0] shl_last;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] rot_l;
  logic             amt_nz;
  logic [WIDTH-1:0] sc_acc1;
  logic [WIDTH-1:0] sc_acc2;
  logic             sc_c;
  logic             sc_v;
  logic             sc_known;
  logic             sc_iter;

  always_comb begin
    op         = bus.opcode[5:1];
    a          = bus.A;
    b          = bus.B;
    amt        = b[SH_W-1:0];
    amt_nz     = (amt != '0);
    addend     = (op == OP_INC) ? WIDTH'(1) : b;
    subtrahend = (op == OP_DEC) ? WIDTH'(1) : b;
    add_full   = {1'b0, a} + {1'b0, addend};
    sub_full   = {1'b0, a} - {1'b0, subtrahend};
    add_ovf    = (a[WIDTH-1] == addend[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_ovf    = (a[WIDTH-1] != subtrahend[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    shr_last   = a >> (amt - SH_W'(1));
    shl_last   = a << (amt - SH_W'(1));
    rot_r      = (a >> amt) | (a << ((SH_W+1)'(WIDTH) - {1'b0, amt}));
    rot_l      = (a << amt) | (a >> ((SH_W+1)'(WIDTH) - {1'b0, amt}));

    sc_acc1  = '0;
    sc_acc2  = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_known = 1'b1;
    sc_iter  = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        sc_acc1 = add_full[WIDTH-1:0];
        sc_c    = add_full[WIDTH];
        sc_v    = add_ovf;
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        sc_acc1 = sub_full[WIDTH-1:0];
        sc_c    = sub_full[WIDTH];
        sc_v    = sub_ovf;
      end
      OP_LSR: begin
        sc_acc1 = a >> amt;
        sc_c    = amt_nz & shr_last[0];
      end
      OP_LSL: begin
        sc_acc1 = a << amt;
        sc_c    = amt_nz & shl_last[WIDTH-1];
      end
      // The last bit to wrap is the same bit a logical shift would have pushed out.
      OP_RSR: begin
        sc_acc1 = rot_r;
        sc_c    = amt_nz & shr_last[0];
      end
      OP_RSL: begin
        sc_acc1 = rot_l;
        sc_c    = amt_nz & shl_last[WIDTH-1];
      end
      OP_MOV:         sc_acc1 = b;
      OP_AND, OP_TST: sc_acc1 = a & b;
      OP_OR:          sc_acc1 = a | b;
      OP_XOR:         sc_acc1 = a ^ b;
      OP_NOT:         sc_acc1 = ~a;
      OP_MUL:         sc_iter = 1'b1;
      OP_DIV, OP_MOD: begin
        if (b != '0) begin
          sc_iter = 1'b1;
        end else begin
          sc_acc1 = (op == OP_DIV) ? '1 : a;
          sc_acc2 = (op == OP_DIV) ? a : '1;
          sc_v    = 1'b1;
        end
      end
      default:        sc_known = 1'b0;
    endcase
  end

  // One iteration step: MUL keeps {hi,lo} as partial product / multiplier,
  // DIV/MOD keeps hi as partial remainder and lo as dividend shifting into quotient.
  logic             is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fin_acc1;
  logic [WIDTH-1:0] fin_acc2;
  logic             fin_c;

  always_comb begin
    is_mul    = (op_code == OP_MUL);
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, op_b};
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], ~div_trial[WIDTH]};
    end
    fin_c = 1'b0;
    if (op_code == OP_MOD) begin
      fin_acc1 = step_hi;
      fin_acc2 = step_lo;
    end else begin
      fin_acc1 = step_lo;
      fin_acc2 = step_hi;
      fin_c    = is_mul & (step_hi != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_code    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.bgn) begin
            op_code <= op;
            op_a    <= a;
            op_b    <= b;
            cnt     <= '0;
            if (sc_iter) begin
              work_hi <= '0;
              work_lo <= (op == OP_MUL) ? b : a;
              state   <= CALC;
            end else begin
              acc1_q <= sc_acc1;
              acc2_q <= sc_acc2;
              if (sc_known) begin
                zero_q     <= (sc_acc1 == '0);
                negative_q <= sc_acc1[WIDTH-1];
                carry_q    <= sc_c;
                overflow_q <= sc_v;
              end
              state <= DONE;
            end
          end
        end
        CALC: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            acc1_q     <= fin_acc1;
            acc2_q     <= fin_acc2;
            zero_q     <= (fin_acc1 == '0);
            negative_q <= fin_acc1[WIDTH-1];
            carry_q    <= fin_c;
            overflow_q <= 1'b0;
            cnt        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (bus.bgn) begin
            rdy_q <= 1'b1;
          end else begin
            rdy_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.acc1      = acc1_q;
  assign bus.acc2      = acc2_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.rdy       = rdy_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized scoreboard bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

  localparam int W = 16;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSR = 5'b00011;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_MOV = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;
  localparam logic [4:0] OP_MOD = 5'b01010;
  localparam logic [4:0] OP_AND = 5'b01011;
  localparam logic [4:0] OP_OR  = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_NOT = 5'b01110;
  localparam logic [4:0] OP_CMP = 5'b01111;
  localparam logic [4:0] OP_TST = 5'b10000;
  localparam logic [4:0] OP_INC = 5'b10001;
  localparam logic [4:0] OP_DEC = 5'b10010;

  typedef struct packed {
    logic [W-1:0] acc1;
    logic [W-1:0] acc2;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic [7:0]   lat;
    logic [63:0]  tcap;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  // Model flag state: flags persist across ops and survive unknown opcodes.
  logic mz, mn, mc, mv;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    logic [31:0] wide;
    int sa, sb, sr;
    int unsigned n;
    logic known;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n = int'(b[3:0]);
    known = 1'b1;
    e = '0;
    e.lat = 8'd1;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        if (op == OP_INC) begin sb = 1; wide = 32'(a) + 32'd1; end
        else wide = 32'(a) + 32'(b);
        e.acc1 = wide[15:0];
        e.c = (wide > 32'd65535);
        sr = sa + sb;
        e.v = (sr > 32767) || (sr < -32768);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        if (op == OP_DEC) begin sb = 1; e.acc1 = a - 16'd1; e.c = (a < 16'd1); end
        else begin e.acc1 = a - b; e.c = (a < b); end
        sr = sa - sb;
        e.v = (sr > 32767) || (sr < -32768);
      end
      OP_LSR: begin
        e.acc1 = a >> n;
        e.c = (n == 0) ? 1'b0 : ((a >> (n - 1)) & 16'd1) != 0;
      end
      OP_LSL: begin
        wide = 32'(a) << n;
        e.acc1 = wide[15:0];
        e.c = (n == 0) ? 1'b0 : wide[16];
      end
      OP_RSR: begin
        wide = {a, a} >> n;
        e.acc1 = wide[15:0];
        e.c = (n == 0) ? 1'b0 : e.acc1[15];
      end
      OP_RSL: begin
        wide = {a, a} << n;
        e.acc1 = wide[31:16];
        e.c = (n == 0) ? 1'b0 : e.acc1[0];
      end
      OP_MOV:         e.acc1 = b;
      OP_AND, OP_TST: e.acc1 = a & b;
      OP_OR:          e.acc1 = a | b;
      OP_XOR:         e.acc1 = a ^ b;
      OP_NOT:         e.acc1 = ~a;
      OP_MUL: begin
        wide = 32'(a) * 32'(b);
        e.acc1 = wide[15:0];
        e.acc2 = wide[31:16];
        e.c = (e.acc2 != 0);
        e.lat = 8'd17;
      end
      OP_DIV, OP_MOD: begin
        logic [W-1:0] q, r;
        if (b == 0) begin
          q = 16'hFFFF; r = a; e.v = 1'b1;
        end else begin
          q = a / b; r = a % b; e.lat = 8'd17;
        end
        e.acc1 = (op == OP_DIV) ? q : r;
        e.acc2 = (op == OP_DIV) ? r : q;
      end
      default: begin
        known = 1'b0;
        e.acc1 = '0;
      end
    endcase
    if (known) begin
      mz = (e.acc1 == 0);
      mn = e.acc1[15];
      mc = e.c;
      mv = e.v;
    end
    e.z = mz; e.n = mn; e.c = mc; e.v = mv;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_rdy;
    exp_t cur;
    logic [63:0] edge_t;
    prev_rdy = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk);
      edge_t = $time;
      #1;
      if (bus.rdy === 1'b1 && prev_rdy !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rdy", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("acc1", bus.acc1, cur.acc1);
          chk("acc2", bus.acc2, cur.acc2);
          chk("zero", bus.zero, cur.z);
          chk("negative", bus.negative, cur.n);
          chk("carry", bus.carry, cur.c);
          chk("overflow", bus.overflow, cur.v);
          chk("latency", (edge_t - cur.tcap) / 10, 64'(cur.lat));
        end
      end else if (bus.rdy === 1'b1) begin
        chk("held_outputs", {bus.acc1, bus.acc2, bus.zero, bus.negative, bus.carry, bus.overflow},
            {cur.acc1, cur.acc2, cur.z, cur.n, cur.c, cur.v});
      end
      prev_rdy = bus.rdy;
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    exp_t e;
    bit seen;
    @(negedge clk);
    bus.opcode = {op, 1'($urandom_range(0, 1))};
    bus.A = a;
    bus.B = b;
    bus.bgn = 1'b1;
    @(posedge clk);
    model(op, a, b, e);
    e.tcap = $time;
    exp_q.push_back(e);
    // Inputs may wander after capture; the DUT must ignore them.
    @(negedge clk);
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    bus.opcode = 6'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("rdy_timeout", 64'(bus.rdy), 64'd1);
      void'(exp_q.pop_back());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rdy_held", 64'(bus.rdy), 64'd1);
      chk("state_held_done", 64'(bus.state_dbg), 64'd2);
    end
    bus.bgn = 1'b0;
    @(negedge clk);
    chk("rdy_drop", 64'(bus.rdy), 64'd0);
    chk("state_idle", 64'(bus.state_dbg), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acc1"}, bus.acc1, 0);
    chk({tag, "_acc2"}, bus.acc2, 0);
    chk({tag, "_flags"}, {bus.zero, bus.negative, bus.carry, bus.overflow}, 0);
    chk({tag, "_rdy"}, bus.rdy, 0);
    chk({tag, "_state"}, bus.state_dbg, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] op;
    logic [W-1:0] a, b;
    n_checks = 0;
    n_fail = 0;
    mz = 0; mn = 0; mc = 0; mv = 0;
    rst = 1'b1;
    bus.bgn = 1'b0;
    bus.opcode = '0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases from the test plan
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 0);
    run_op(OP_SUB, 16'h0003, 16'h0005, 0);
    run_op(OP_CMP, 16'h1234, 16'h1234, 0);
    run_op(OP_MUL, 16'h1234, 16'h0100, 5);
    run_op(OP_DIV, 16'd100, 16'd7, 0);
    run_op(OP_MOD, 16'd100, 16'd7, 0);
    run_op(OP_DIV, 16'h0042, 16'h0000, 0);
    run_op(OP_MOD, 16'h0042, 16'h0000, 0);
    run_op(OP_RSL, 16'h8001, 16'h0001, 0);
    run_op(OP_LSR, 16'h0003, 16'h0001, 0);
    run_op(OP_LSL, 16'hA5C3, 16'h0010, 0);
    run_op(OP_RSR, 16'h0001, 16'h0001, 0);
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 5);
    run_op(5'b00000, 16'h1111, 16'h2222, 0);
    run_op(5'b11111, 16'h0000, 16'h0000, 1);
    run_op(OP_INC, 16'h7FFF, 16'h0000, 0);
    run_op(OP_DEC, 16'h8000, 16'h0000, 0);
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0);
    run_op(OP_DIV, 16'hFFFF, 16'h0001, 0);

    // Randomized mix, including unlisted opcodes and divide-by-zero
    for (int i = 0; i < 70; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) op = 5'($urandom_range(8, 10));
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      run_op(op, a, b, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.opcode = {OP_MUL, 1'b0};
    bus.A = 16'h1234;
    bus.B = 16'h5678;
    bus.bgn = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midmul_reset");
    mz = 0; mn = 0; mc = 0; mv = 0;
    bus.bgn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_ADD, 16'd2, 16'd3, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
